// File: rtl/alu_seq_if.sv
// Request, response and ALU-side signal bundle for alu_sequencer.
// slave = the sequencer itself; master = the requester/ALU environment.
interface alu_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_zhi;
    logic [31:0] alu_zlo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
        output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_hi, rsp_lo,
               rsp_err, busy, op_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_zhi, alu_zlo, rsp_ready,
        input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_hi, rsp_lo,
               rsp_err, busy, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the combinational ALU: accepts one op, drives the
// ALU for a fixed latency, and returns the captured result (or an error).
module alu_sequencer #(
    parameter int unsigned SIMPLE_LAT = 1,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic      clk,
    input  logic      clr,
    alu_seq_if.slave  bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OPC_W  = 16;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   rsp_hi_q, rsp_hi_d;
    logic [DATA_W-1:0]   rsp_lo_q, rsp_lo_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic [OPC_W-1:0]    op_count_q, op_count_d;

    logic req_md_c, req_shift_c, req_bad_c, op_md_c;

    // Request decode: mul/div latency class, shift-amount masking, screening
    assign req_md_c    = (bus.req_op == OP_W'(8)) || (bus.req_op == OP_W'(9));
    assign req_shift_c = (bus.req_op >= OP_W'(2)) && (bus.req_op <= OP_W'(5));
    assign req_bad_c   = (bus.req_op > OP_W'(11)) ||
                         ((bus.req_op == OP_W'(9)) && (bus.req_b == '0));
    assign op_md_c     = (op_q == OP_W'(8)) || (op_q == OP_W'(9));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            alu_ctrl_q  <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d = bus.req_op;
                    if (req_bad_c) begin
                        // Screened op never reaches the ALU
                        rsp_err_d = 1'b1;
                        rsp_hi_d  = '0;
                        rsp_lo_d  = '0;
                        state_d   = DONE;
                    end else begin
                        alu_a_d    = bus.req_a;
                        alu_b_d    = req_shift_c
                                   ? DATA_W'(bus.req_b[SHAMT_W-1:0]) : bus.req_b;
                        alu_ctrl_d = CTRL_W'(1) << bus.req_op;
                        cnt_d      = req_md_c ? CNT_W'(MULDIV_LAT - 1)
                                              : CNT_W'(SIMPLE_LAT - 1);
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_lo_d   = bus.alu_zlo;
                    rsp_hi_d   = op_md_c ? bus.alu_zhi : '0;
                    rsp_err_d  = 1'b0;
                    alu_ctrl_d = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + OPC_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                alu_ctrl_d = '0;
                state_d    = IDLE;
            end
        endcase

        // Status flags registered from the next state so they track it exactly
        rsp_valid_d = (state_d == DONE);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hi    = rsp_hi_q;
    assign bus.rsp_lo    = rsp_lo_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
    assign bus.op_count  = op_count_q;
endmodule
